// File: rtl/perceptron_pkg.sv
// Shared constants and FSM encoding for the perceptron datapath.
package perceptron_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WINDOW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/serial_shift_in.sv
// MSB-first serial-to-parallel assembler with a completion strobe on the final bit.
module serial_shift_in
  import perceptron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              sdi_i,
  input  logic              accept_i,
  output logic              last_o,
  output logic              done_o,
  output logic [DATA_W-1:0] word_o
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [DATA_W-2:0] shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;

  // word_o is the byte that would be complete if the current bit were taken
  assign word_o = {shreg_q, sdi_i};
  assign last_o = (bit_cnt_q == LAST);
  assign done_o = accept_i && !flush_i && last_o;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (flush_i) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (accept_i) begin
      shreg_d   = word_o[DATA_W-2:0];
      bit_cnt_d = last_o ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/perceptron_feeder.sv
// Serial sample feeder: assembles bits, double-buffers them and holds each
// sample stable on current for a WINDOW-cycle evaluation window.
module perceptron_feeder
  import perceptron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              sdi,
  input  logic              sdi_valid,
  output logic              sdi_ready,
  output logic [DATA_W-1:0] current,
  output logic              frame_start,
  output logic              busy,
  output logic [7:0]        frame_count
);

  localparam int WCW = $clog2(WINDOW);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] current_q, current_d;
  logic [WCW-1:0]    win_cnt_q, win_cnt_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              last_bit, accept, byte_done, load;
  logic [DATA_W-1:0] byte_word;

  // Only the completing bit stalls; partial bits may refill behind a full pend
  assign sdi_ready = !(pend_valid_q && last_bit);
  assign accept    = sdi_valid && sdi_ready;

  serial_shift_in #(.DATA_W(DATA_W)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .sdi_i   (sdi),
    .accept_i(accept),
    .last_o  (last_bit),
    .done_o  (byte_done),
    .word_o  (byte_word)
  );

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    current_d     = current_q;
    win_cnt_d     = win_cnt_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    load          = 1'b0;

    case (state_q)
      IDLE: load = pend_valid_q;
      RUN: begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (win_cnt_q == WIN_LAST) begin
          if (pend_valid_q) load = 1'b1;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      current_d     = pend_q;
      pend_valid_d  = 1'b0;
      frame_start_d = 1'b1;
      win_cnt_d     = '0;
      frame_count_d = frame_count_q + 8'd1;
      state_d       = RUN;
    end

    // A newly completed byte wins over the consume of the old one
    if (byte_done) begin
      pend_d       = byte_word;
      pend_valid_d = 1'b1;
    end

    if (flush) begin
      state_d       = IDLE;
      pend_valid_d  = 1'b0;
      current_d     = '0;
      win_cnt_d     = '0;
      frame_start_d = 1'b0;
      frame_count_d = frame_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      current_q     <= '0;
      win_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      current_q     <= current_d;
      win_cnt_q     <= win_cnt_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign current     = current_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == RUN);
  assign frame_count = frame_count_q;

endmodule
